// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size and FSM state types shared by the LSU modules
package lsu_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_WORDX = 2'b11
    } mem_size_t;
    typedef enum logic [2:0] {IDLE, BUS_RD, BUS_WR, RMW_RD, RMW_GAP, RMW_WR, RESP} lsu_state_t;
    // Encoding 11 behaves as a full word
    function automatic logic is_word(mem_size_t s);
        return s[1];
    endfunction
    function automatic logic misaligned(mem_size_t s, logic [1:0] a);
        return is_word(s) ? (a != 2'b00) : ((s == SZ_HALF) && a[0]);
    endfunction
endpackage

// File: rtl/defines.svh
// defines.svh: shared address and data widths for the LSU bus interface
`ifndef LSU_DEFINES_SVH
`define LSU_DEFINES_SVH
`define ADDR_SIZE 32
`define WORD_SIZE 32
`endif

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extraction with sign/zero extension for loads,
// and lane merge of store data into a read word for sub-word stores
`include "defines.svh"
module lsu_align
    import lsu_pkg::*;
(
    input  mem_size_t             size,
    input  logic                  sgn,
    input  logic [1:0]            lane,
    input  logic [`WORD_SIZE-1:0] rdata,
    input  logic [`WORD_SIZE-1:0] wdata,
    output logic [`WORD_SIZE-1:0] load_data,
    output logic [`WORD_SIZE-1:0] merge_data
);
    logic [4:0]            shift;
    logic [7:0]            lb;
    logic [15:0]           lh;
    logic [`WORD_SIZE-1:0] mask;
    always_comb begin
        shift = (size == SZ_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
        lb = 8'(rdata >> shift);
        lh = 16'(rdata >> shift);
        mask = ((size == SZ_HALF) ? `WORD_SIZE'('hFFFF) : `WORD_SIZE'('hFF)) << shift;
        load_data = is_word(size) ? rdata
                  : (size == SZ_HALF) ? {{(`WORD_SIZE-16){sgn & lh[15]}}, lh}
                  : {{(`WORD_SIZE-8){sgn & lb[7]}}, lb};
        merge_data = is_word(size) ? wdata : (rdata & ~mask) | ((wdata << shift) & mask);
    end
endmodule

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: core load/store requests to Wishbone-style bus cycles, with
// read-modify-write for sub-word stores; LSU_TIMEOUT_EN adds a bus timeout
`include "defines.svh"
module lsu_wb_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req_valid,
    output logic                  Req_ready,
    input  logic                  Req_we,
    input  logic [1:0]            Req_size,
    input  logic                  Req_signed,
    input  logic [`ADDR_SIZE-1:0] Req_addr,
    input  logic [`WORD_SIZE-1:0] Req_wdata,
    output logic                  Rsp_valid,
    output logic                  Rsp_err,
    output logic [`WORD_SIZE-1:0] Rsp_rdata,
    output logic [`ADDR_SIZE-1:0] Wb_addr,
    output logic                  Wb_cs,
    output logic                  Wb_we,
    output logic [`WORD_SIZE-1:0] Wb_wdata,
    input  logic [`WORD_SIZE-1:0] Wb_rdata,
    input  logic                  Wb_ack
);
    lsu_state_t            state, state_next;
    mem_size_t             size_q;
    logic                  sgn_q, err_q, tmo, accept, mis;
    logic [`ADDR_SIZE-1:0] addr_q;
    logic [`WORD_SIZE-1:0] word_q, load_data, merge_data;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign accept = (state == IDLE) && Req_valid;
    assign mis = misaligned(mem_size_t'(Req_size), Req_addr[1:0]);

    lsu_align u_align (
        .size      (size_q),
        .sgn       (sgn_q),
        .lane      (addr_q[1:0]),
        .rdata     (Wb_rdata),
        .wdata     (word_q),
        .load_data (load_data),
        .merge_data(merge_data)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Req_valid) state_next = mis ? RESP : !Req_we ? BUS_RD
                                            : is_word(mem_size_t'(Req_size)) ? BUS_WR : RMW_RD;
            BUS_RD, BUS_WR, RMW_WR: if (Wb_ack || tmo) state_next = RESP;
            RMW_RD: state_next = Wb_ack ? RMW_GAP : tmo ? RESP : RMW_RD;
            RMW_GAP: state_next = RMW_WR;
            default: state_next = IDLE;
        endcase
    end

    // word_q holds store data, then the merged word, then the response data
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            size_q <= SZ_BYTE;
            sgn_q  <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            word_q <= '0;
        end else if (accept) begin
            size_q <= mem_size_t'(Req_size);
            sgn_q  <= Req_signed;
            err_q  <= mis;
            addr_q <= Req_addr;
            word_q <= mis ? '0 : Req_wdata;
        end else if (Wb_cs && Wb_ack) begin
            word_q <= (state == BUS_RD) ? load_data : (state == RMW_RD) ? merge_data : '0;
        end else if (tmo) begin
            err_q  <= 1'b1;
            word_q <= '0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt;
    always_ff @(posedge Clk) begin
        if (!Rst) cnt <= '0;
        else cnt <= Wb_cs ? cnt + 8'd1 : 8'd0;
    end
    assign tmo = Wb_cs && !Wb_ack && (cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        Req_ready = state == IDLE;
        Rsp_valid = state == RESP;
        Rsp_err   = Rsp_valid && err_q;
        Rsp_rdata = Rsp_valid ? word_q : '0;
        Wb_cs     = state inside {BUS_RD, BUS_WR, RMW_RD, RMW_WR};
        Wb_we     = state inside {BUS_WR, RMW_WR};
        Wb_addr   = Wb_cs ? {addr_q[`ADDR_SIZE-1:2], 2'b00} : '0;
        Wb_wdata  = Wb_we ? word_q : '0;
    end
endmodule

// File: tb/tb_lsu_wb_master.sv
// tb_lsu_wb_master: directed vector table, reset/timeout sequences and random
// traffic against a byte-array reference model, with a registered-ack RAM slave
module tb_lsu_wb_master;
    localparam int TO = 4;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, req_signed = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, wb_cs, wb_we, wb_ack;
    logic [31:0] rsp_rdata, wb_addr, wb_wdata;
    logic [31:0] wb_rdata = 0;

    always #5 clk = ~clk;

    lsu_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(clk), .Rst(rst_n),
        .Req_valid(req_valid), .Req_ready(req_ready), .Req_we(req_we), .Req_size(req_size),
        .Req_signed(req_signed), .Req_addr(req_addr), .Req_wdata(req_wdata),
        .Rsp_valid(rsp_valid), .Rsp_err(rsp_err), .Rsp_rdata(rsp_rdata),
        .Wb_addr(wb_addr), .Wb_cs(wb_cs), .Wb_we(wb_we), .Wb_wdata(wb_wdata),
        .Wb_rdata(wb_rdata), .Wb_ack(wb_ack)
    );

    int total = 0, bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM slave: ack one cycle after seeing cs; optional spurious acks while cs is low
    logic [31:0] ram [16] = '{default: 32'h0};
    logic ack_r = 0, spur = 0, ack_en = 1, spur_en = 0;
    assign wb_ack = ack_r | spur;
    always @(posedge clk) begin
        if (!rst_n) ack_r <= 1'b0;
        else begin
            ack_r <= ack_en && wb_cs && !ack_r;
            if (ack_en && wb_cs && !ack_r) begin
                wb_rdata <= ram[wb_addr[5:2]];
                if (wb_we) ram[wb_addr[5:2]] <= wb_wdata;
            end
        end
    end
    always @(negedge clk) spur = spur_en && !wb_cs && ($urandom_range(0, 1) == 1);

    // Bus monitor
    int pulses = 0, writes = 0, cs_cycles = 0, rsp_pulses = 0;
    logic cs_prev = 0;
    logic [31:0] exp_waddr = 0, exp_wword = 0;
    always @(negedge clk) begin
        if (wb_cs && !cs_prev) pulses++;
        if (wb_cs) begin
            cs_cycles++;
            check("wb_addr", wb_addr, exp_waddr);
        end
        if (wb_cs && wb_we && ack_r) begin
            writes++;
            check("wb_wdata", wb_wdata, exp_wword);
        end
        if (rsp_valid) rsp_pulses++;
        cs_prev = wb_cs;
    end

    // Reference model: byte-addressed memory, sizes as byte counts
    logic [7:0] mb [64] = '{default: 8'h00};
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic e_err, output logic [31:0] e_rd);
        int n = nbytes(size);
        int a = int'(addr[5:0]);
        int w = a - a % 4;
        longint v = 0;
        e_err = (addr % n) != 0;
        e_rd = 0;
        if (!e_err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mb[a + i] = 8'(wdata >> (8 * i));
                exp_wword = {mb[w + 3], mb[w + 2], mb[w + 1], mb[w]};
            end else begin
                for (int i = 0; i < n; i++) v += longint'(mb[a + i]) << (8 * i);
                if (sgn && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v -= (64'sd1 <<< (8 * n));
                e_rd = 32'(v);
            end
        end
    endtask

    task automatic run_op(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic err, output logic [31:0] rdata, output int lat);
        int n = 0;
        exp_waddr = {addr[31:2], 2'b00};
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", req_ready, 1);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1;
        @(posedge clk);
        #1;
        req_valid = 0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 100);
        if (!rsp_valid) check("rsp_wait", rsp_valid, 1);
        err = rsp_err;
        rdata = rsp_rdata;
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr, wdata;
        logic        err;
        logic [31:0] rdata;
        int          pulses, writes, lat;
    } vec_t;
    vec_t tbl [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        g_err, e_err;
        logic [31:0] g_rd, e_rd;
        int          lat, p0, w0, c0, r0;
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h0, 32'hAAAAAAAA, 1'b0, 32'h0,        1, 1, 3};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,        1'b0, 32'hAAAAAAAA, 1, 0, 3};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344, 1'b0, 32'h0,        1, 1, 3};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h5, 32'h123456EE, 1'b0, 32'h0,        2, 1, 6};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        1'b0, 32'h1122EE44, 1, 0, 3};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'h0000F080, 1'b0, 32'h0,        1, 1, 3};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h8, 32'h0,        1'b0, 32'hFFFFF080, 1, 0, 3};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h8, 32'h0,        1'b0, 32'h0000F080, 1, 0, 3};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h9, 32'h0,        1'b0, 32'hFFFFFFF0, 1, 0, 3};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0,        1'b1, 32'h0,        0, 0, 1};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h3, 32'h0,        1'b1, 32'h0,        0, 0, 1};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'hA, 32'hCAFEBEEF, 1'b0, 32'h0,        2, 1, 6};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        1'b0, 32'hBEEFF080, 1, 0, 3};
        tbl[13] = '{1'b1, 2'd3, 1'b0, 32'hC, 32'h12345678, 1'b0, 32'h0,        1, 1, 3};
        tbl[14] = '{1'b0, 2'd3, 1'b1, 32'hC, 32'h0,        1'b0, 32'h12345678, 1, 0, 3};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 32'hF, 32'h0,        1'b0, 32'h00000012, 1, 0, 3};
        tbl[16] = '{1'b1, 2'd2, 1'b0, 32'h2, 32'hFFFFFFFF, 1'b1, 32'h0,        0, 0, 1};
        tbl[17] = '{1'b0, 2'd1, 1'b1, 32'h6, 32'h0,        1'b0, 32'h00001122, 1, 0, 3};

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_wb_cs", wb_cs, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_wdata", wb_wdata, 0);
        rst_n = 1;

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, e_err, e_rd);
            p0 = pulses;
            w0 = writes;
            run_op(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, g_err, g_rd, lat);
            check($sformatf("vec%0d_err", i), g_err, tbl[i].err);
            check($sformatf("vec%0d_rdata", i), g_rd, tbl[i].rdata);
            check($sformatf("vec%0d_cs_pulses", i), pulses - p0, tbl[i].pulses);
            check($sformatf("vec%0d_writes", i), writes - w0, tbl[i].writes);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
        end

        // Reset in the middle of a word store that never gets an ack
        ack_en = 0;
        exp_waddr = 32'h10;
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_signed = 0; req_addr = 32'h10; req_wdata = 32'h5555AAAA;
        req_valid = 1;
        @(posedge clk);
        #1;
        req_valid = 0;
        @(negedge clk);
        check("bus_wr_cs", wb_cs, 1);
        check("bus_wr_we", wb_we, 1);
        @(negedge clk);
        r0 = rsp_pulses;
        rst_n = 0;
        @(posedge clk);
        #1;
        check("midrst_wb_cs", wb_cs, 0);
        check("midrst_wb_we", wb_we, 0);
        check("midrst_wb_wdata", wb_wdata, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        check("midrst_no_rsp", rsp_pulses - r0, 0);
        ack_en = 1;

`ifdef LSU_TIMEOUT_EN
        ack_en = 0;
        c0 = cs_cycles;
        run_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, g_err, g_rd, lat);
        check("to_load_err", g_err, 1);
        check("to_load_rdata", g_rd, 0);
        check("to_load_cs_cycles", cs_cycles - c0, TO);
        check("to_load_latency", lat, TO + 1);
        p0 = pulses;
        w0 = writes;
        run_op(1'b1, 2'd0, 1'b0, 32'h1, 32'h77, g_err, g_rd, lat);
        check("to_rmw_err", g_err, 1);
        check("to_rmw_pulses", pulses - p0, 1);
        check("to_rmw_writes", writes - w0, 0);
        ack_en = 1;
`endif

        spur_en = 1;
        for (int i = 0; i < 300; i++) begin
            logic        we, sgn;
            logic [1:0]  size;
            logic [31:0] addr, wdata;
            we = 1'($urandom);
            sgn = 1'($urandom);
            size = 2'($urandom);
            addr = $urandom;
            wdata = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(size) - 1);
            model(we, size, sgn, addr, wdata, e_err, e_rd);
            run_op(we, size, sgn, addr, wdata, g_err, g_rd, lat);
            check($sformatf("rnd%0d_err", i), g_err, e_err);
            check($sformatf("rnd%0d_rdata", i), g_rd, e_rd);
        end
        spur_en = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            check($sformatf("ram%0d", i), ram[i], {mb[4 * i + 3], mb[4 * i + 2], mb[4 * i + 1], mb[4 * i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_wb_master.md
LSU_WB_MASTER -- requirements
Module: lsu_wb_master

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of Wb_cs-high cycles without Wb_ack before abort (1..255).
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-low.
REQ-004 Req_valid  input  1  core request strobe.
REQ-005 Req_ready  output  1  high only in IDLE; a request is accepted on an edge where Req_valid && Req_ready.
REQ-006 Req_we  input  1  1 = store, 0 = load.
REQ-007 Req_size  input  2  access size: BYTE=00, HALF=01, WORD=10; 11 is treated as WORD.
REQ-008 Req_signed  input  1  load sign-extend (1) or zero-extend (0).
REQ-009 Req_addr  input  `ADDR_SIZE  byte address.
REQ-010 Req_wdata  input  `WORD_SIZE  store data, right-aligned.
REQ-011 Rsp_valid  output  1  one-cycle completion pulse.
REQ-012 Rsp_err  output  1  qualifies Rsp_valid: misaligned access or timeout.
REQ-013 Rsp_rdata  output  `WORD_SIZE  extended load data; 0 for stores and errors.
REQ-014 Wb_addr  output  `ADDR_SIZE  word-aligned bus address (bits [1:0] = 0).
REQ-015 Wb_cs  output  1  bus cycle select.
REQ-016 Wb_we  output  1  bus write enable.
REQ-017 Wb_wdata  output  `WORD_SIZE  bus write data.
REQ-018 Wb_rdata  input  `WORD_SIZE  bus read data, valid when Wb_ack is high.
REQ-019 Wb_ack  input  1  slave completion, one cycle.

Function
REQ-020 States SHALL be IDLE, BUS_RD, BUS_WR, RMW_RD, RMW_GAP, RMW_WR, RESP; IDLE is the only state accepting requests.
REQ-021 Misalignment (HALF with addr[0]=1, WORD with addr[1:0]!=0) SHALL cause IDLE->RESP without any bus cycle: Rsp_valid=1, Rsp_err=1, Rsp_rdata=0 one cycle after acceptance.
REQ-022 Aligned load SHALL go IDLE->BUS_RD, holding Wb_cs=1, Wb_we=0 and Wb_addr={addr[31:2],2'b00} from the cycle after acceptance until Wb_ack is sampled high.
REQ-023 Aligned WORD store SHALL go IDLE->BUS_WR with Wb_we=1 and Wb_wdata=Req_wdata until Wb_ack.
REQ-024 BYTE/HALF store SHALL go RMW_RD (bus read) -> RMW_GAP (Wb_cs=0, one cycle) -> RMW_WR, which writes the read word with the addressed lane(s) replaced, little-endian (lane = addr[1:0]).
REQ-025 On Wb_ack in BUS_RD/BUS_WR/RMW_WR the FSM SHALL enter RESP, dropping Wb_cs, Wb_we and Wb_wdata to 0 on that same edge; RESP lasts one cycle, then IDLE.
REQ-026 Load data SHALL be extracted from byte lane addr[1:0] (HALF: addr[1]) and sign- or zero-extended per Req_signed; a WORD load returns Wb_rdata unchanged.
REQ-027 Wb_cs SHALL be low for at least one cycle between any two bus transactions; minimum load latency is acceptance -> Rsp_valid = 3 edges with a one-cycle-ack slave.
REQ-028 Wb_ack sampled while Wb_cs=0 SHALL be ignored.
REQ-029 Req_valid while Req_ready=0 SHALL be ignored; request fields are registered at acceptance and need not be held.

Reset
REQ-030 With Rst=0 at an edge, the FSM SHALL go to IDLE and all outputs to 0 except Req_ready=1, including mid-transaction; no Rsp_valid SHALL be issued for the aborted request.

Configuration
REQ-031 Macro LSU_TIMEOUT_EN defined: an 8-bit counter clears on each bus-cycle start and counts cycles with Wb_cs=1; when it reaches TIMEOUT_CYCLES without ack, Wb_cs drops and RESP is entered with Rsp_err=1 (an RMW aborts in either phase, with no write on a read timeout); ack on the expiry cycle wins.
REQ-032 Macro undefined: no counter; the master waits for Wb_ack indefinitely, and Rsp_err reports misalignment only.

Structure
REQ-033 Widths SHALL come from the shared defines.svh; a shared package lsu_pkg SHALL hold mem_size_t and the lsu_state_t enum.
REQ-034 Lane extract/merge SHALL be a combinational sub-module lsu_align; the FSM, registers and timeout counter remain in lsu_wb_master.

Verification
REQ-035 With the existing ram, store WORD 0x0 = 0xAAAAAAAA, then load WORD 0x0 -> one bus write, then Rsp_rdata=0xAAAAAAAA, Rsp_err=0.
REQ-036 Word 0x4 = 0x11223344; store BYTE 0x5 = 0xEE -> read 0x4, Wb_cs low one cycle, write 0x1122EE44.
REQ-037 Word 0x8 = 0x0000F080; load HALF 0x8 signed -> 0xFFFFF080; unsigned -> 0x0000F080; BYTE 0x9 signed -> 0xFFFFFFF0.
REQ-038 Load WORD 0x6 -> no Wb_cs assertion; Rsp_valid=1, Rsp_err=1 one cycle after acceptance.
REQ-039 Under LSU_TIMEOUT_EN with Wb_ack tied 0 and TIMEOUT_CYCLES=4, a load -> Wb_cs high 4 cycles, then Rsp_err=1.
REQ-040 Rst=0 asserted during BUS_WR -> Wb_cs=0 after the next edge, no Rsp_valid, Req_ready=1.
